// File: rtl/l1_mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_mem_arb_pkg : shared opcodes, FSM states and grant IDs           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package l1_mem_arb_pkg;

  localparam logic [2:0] COP_RD = 3'b000;
  localparam logic [2:0] COP_WR = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic GNT_IL1 = 1'b0;
  localparam logic GNT_DL1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/l1_mem_arb_rr2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_mem_arb_rr2 : combinational 2-way round-robin picker             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module l1_mem_arb_rr2
  import l1_mem_arb_pkg::*;
(
  input  logic i_req_il1,
  input  logic i_req_dl1,
  input  logic i_last_gnt,
  output logic o_gnt_val,
  output logic o_gnt_id
);

  always_comb begin
    o_gnt_val = i_req_il1 | i_req_dl1;
    o_gnt_id  = GNT_IL1;
    if (i_req_il1 && i_req_dl1) begin
      // On a tie the requester that did not win last time goes next.
      o_gnt_id = ~i_last_gnt;
    end else if (i_req_dl1) begin
      o_gnt_id = GNT_DL1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_mem_arb : il1/dl1 arbiter onto one memory port, with timeout     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module l1_mem_arb
  import l1_mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          il12arb_val,
  input  logic [AW-1:0] il12arb_addr,
  output logic          arb2il1_ack,
  output logic [DW-1:0] arb2il1_rdata,
  input  logic          dl12arb_val,
  input  logic [AW-1:0] dl12arb_addr,
  input  logic [2:0]    dl12arb_cop,
  input  logic [DW-1:0] dl12arb_wdata,
  input  logic [3:0]    dl12arb_be,
  output logic          arb2dl1_ack,
  output logic [DW-1:0] arb2dl1_rdata,
  output logic          arb_err,
  output logic          arb2mem_val,
  output logic [AW-1:0] arb2mem_addr,
  output logic          arb2mem_we,
  output logic [DW-1:0] arb2mem_wdata,
  output logic [3:0]    arb2mem_be,
  input  logic          mem2arb_ack,
  input  logic [DW-1:0] mem2arb_rdata
);

  localparam int             C_CW      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [C_CW-1:0] C_TO_LAST = (TIMEOUT_CYC == 0) ? '0 : C_CW'(TIMEOUT_CYC - 1);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic            r_last_gnt;
  logic            r_gnt;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [DW-1:0]   r_wdata;
  logic [3:0]      r_be;
  logic [C_CW-1:0] r_cnt;
  logic            r_err;
  logic [DW-1:0]   r_il1_rdata;
  logic [DW-1:0]   r_dl1_rdata;
  logic            w_gnt_val;
  logic            w_gnt_id;
  logic            w_timeout;

  l1_mem_arb_rr2 u_rr2 (
    .i_req_il1  (il12arb_val),
    .i_req_dl1  (dl12arb_val),
    .i_last_gnt (r_last_gnt),
    .o_gnt_val  (w_gnt_val),
    .o_gnt_id   (w_gnt_id)
  );

  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == C_TO_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_val) w_state_nxt = ST_REQ;
      ST_REQ:  if (mem2arb_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_last_gnt  <= GNT_DL1;
      r_gnt       <= GNT_IL1;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= 4'h0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_il1_rdata <= '0;
      r_dl1_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_val) begin
            r_gnt      <= w_gnt_id;
            r_last_gnt <= w_gnt_id;
            r_cnt      <= '0;
            if (w_gnt_id == GNT_DL1) begin
              r_addr  <= dl12arb_addr;
              r_we    <= (dl12arb_cop == COP_WR);
              r_wdata <= dl12arb_wdata;
              r_be    <= dl12arb_be;
            end else begin
              r_addr  <= il12arb_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
              r_be    <= 4'hF;
            end
          end
        end
        ST_REQ: begin
          if (r_cnt != '1) r_cnt <= r_cnt + C_CW'(1);
          // A memory ack takes priority over a timeout firing in the same cycle.
          if (mem2arb_ack) begin
            r_err <= 1'b0;
            if (r_gnt == GNT_IL1) r_il1_rdata <= mem2arb_rdata;
            else                  r_dl1_rdata <= mem2arb_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_gnt == GNT_IL1) r_il1_rdata <= '0;
            else                  r_dl1_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign arb2mem_val   = (r_state == ST_REQ);
  assign arb2mem_addr  = r_addr;
  assign arb2mem_we    = r_we;
  assign arb2mem_wdata = r_wdata;
  assign arb2mem_be    = r_be;
  assign arb2il1_ack   = (r_state == ST_RESP) && (r_gnt == GNT_IL1);
  assign arb2dl1_ack   = (r_state == ST_RESP) && (r_gnt == GNT_DL1);
  assign arb_err       = (r_state == ST_RESP) && r_err;
  assign arb2il1_rdata = r_il1_rdata;
  assign arb2dl1_rdata = r_dl1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_l1_mem_arb : directed self-checking bench for l1_mem_arb         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_l1_mem_arb;
  import l1_mem_arb_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        il12arb_val;
  logic [31:0] il12arb_addr;
  logic        arb2il1_ack;
  logic [31:0] arb2il1_rdata;
  logic        dl12arb_val;
  logic [31:0] dl12arb_addr;
  logic [2:0]  dl12arb_cop;
  logic [31:0] dl12arb_wdata;
  logic [3:0]  dl12arb_be;
  logic        arb2dl1_ack;
  logic [31:0] arb2dl1_rdata;
  logic        arb_err;
  logic        arb2mem_val;
  logic [31:0] arb2mem_addr;
  logic        arb2mem_we;
  logic [31:0] arb2mem_wdata;
  logic [3:0]  arb2mem_be;
  logic        mem2arb_ack;
  logic [31:0] mem2arb_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  l1_mem_arb #(.AW(32), .DW(32), .TIMEOUT_CYC(4)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .il12arb_val   (il12arb_val),
    .il12arb_addr  (il12arb_addr),
    .arb2il1_ack   (arb2il1_ack),
    .arb2il1_rdata (arb2il1_rdata),
    .dl12arb_val   (dl12arb_val),
    .dl12arb_addr  (dl12arb_addr),
    .dl12arb_cop   (dl12arb_cop),
    .dl12arb_wdata (dl12arb_wdata),
    .dl12arb_be    (dl12arb_be),
    .arb2dl1_ack   (arb2dl1_ack),
    .arb2dl1_rdata (arb2dl1_rdata),
    .arb_err       (arb_err),
    .arb2mem_val   (arb2mem_val),
    .arb2mem_addr  (arb2mem_addr),
    .arb2mem_we    (arb2mem_we),
    .arb2mem_wdata (arb2mem_wdata),
    .arb2mem_be    (arb2mem_be),
    .mem2arb_ack   (mem2arb_ack),
    .mem2arb_rdata (mem2arb_rdata)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    il12arb_val = 1'b0; il12arb_addr = '0;
    dl12arb_val = 1'b0; dl12arb_addr = '0; dl12arb_cop = COP_RD;
    dl12arb_wdata = '0; dl12arb_be = '0;
    mem2arb_ack = 1'b0; mem2arb_rdata = '0;
    tick();
    tick();
    n_tests++;
    if ({arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err, arb2mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
        {arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err, arb2mem_we});
    end
    n_tests++;
    if ({arb2mem_addr, arb2mem_wdata, arb2mem_be} !== 68'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {arb2mem_addr, arb2mem_wdata, arb2mem_be});
    end
    n_tests++;
    if ({arb2il1_rdata, arb2dl1_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {arb2il1_rdata, arb2dl1_rdata});
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_il1_read();
    il12arb_val = 1'b1; il12arb_addr = 32'h100;
    tick();
    n_tests++;
    if ({arb2mem_val, arb2mem_we, arb2mem_be} !== 6'b1_0_1111) begin
      n_fail++; $display("FAIL il1_req1_ctrl: got %b want 101111", {arb2mem_val, arb2mem_we, arb2mem_be});
    end
    n_tests++;
    if (arb2mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL il1_req1_addr: got %h want 00000100", arb2mem_addr);
    end
    il12arb_addr = 32'h999;
    tick();
    n_tests++;
    if (arb2mem_val !== 1'b1 || arb2mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL il1_req2_hold: got val=%b addr=%h want val=1 addr=00000100",
        arb2mem_val, arb2mem_addr);
    end
    mem2arb_ack = 1'b1; mem2arb_rdata = 32'hA5A5_0001;
    tick();
    mem2arb_ack = 1'b0; mem2arb_rdata = 32'h0;
    n_tests++;
    if ({arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err} !== 4'b0100) begin
      n_fail++; $display("FAIL il1_resp_ctrl: got %b want 0100",
        {arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err});
    end
    n_tests++;
    if (arb2il1_rdata !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL il1_resp_rdata: got %h want a5a50001", arb2il1_rdata);
    end
    il12arb_val = 1'b0;
    tick();
    n_tests++;
    if (arb2il1_ack !== 1'b0 || arb2il1_rdata !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL il1_after: got ack=%b rdata=%h want ack=0 rdata=a5a50001",
        arb2il1_ack, arb2il1_rdata);
    end
  endtask

  task automatic test_dl1_write();
    dl12arb_val = 1'b1; dl12arb_addr = 32'h2004; dl12arb_cop = COP_WR;
    dl12arb_wdata = 32'hDEAD_BEEF; dl12arb_be = 4'b0011;
    tick();
    n_tests++;
    if ({arb2mem_val, arb2mem_we, arb2mem_be} !== 6'b1_1_0011) begin
      n_fail++; $display("FAIL dl1_wr_ctrl: got %b want 110011", {arb2mem_val, arb2mem_we, arb2mem_be});
    end
    n_tests++;
    if (arb2mem_addr !== 32'h2004 || arb2mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL dl1_wr_fields: got addr=%h wdata=%h want 00002004 deadbeef",
        arb2mem_addr, arb2mem_wdata);
    end
    mem2arb_ack = 1'b1;
    tick();
    mem2arb_ack = 1'b0;
    n_tests++;
    if ({arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err} !== 4'b0010) begin
      n_fail++; $display("FAIL dl1_wr_resp: got %b want 0010",
        {arb2mem_val, arb2il1_ack, arb2dl1_ack, arb_err});
    end
    dl12arb_val = 1'b0; dl12arb_cop = COP_RD;
    tick();
    n_tests++;
    if ({arb2mem_val, arb2il1_ack, arb2dl1_ack} !== 3'b000) begin
      n_fail++; $display("FAIL dl1_wr_after: got %b want 000", {arb2mem_val, arb2il1_ack, arb2dl1_ack});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    il12arb_val = 1'b1; il12arb_addr = 32'h300;
    dl12arb_val = 1'b1; dl12arb_addr = 32'h400; dl12arb_cop = COP_RD;
    mem2arb_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem2arb_rdata = 32'h1000 + k;
      n_tests++;
      if (arb2mem_val !== 1'b1 || arb2mem_addr !== ((k % 2 == 0) ? 32'h300 : 32'h400)) begin
        n_fail++; $display("FAIL b2b_grant%0d: got val=%b addr=%h want val=1 addr=%h", k,
          arb2mem_val, arb2mem_addr, (k % 2 == 0) ? 32'h300 : 32'h400);
      end
      tick();
      n_tests++;
      if ({arb2il1_ack, arb2dl1_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_ack%0d: got %b want %b", k, {arb2il1_ack, arb2dl1_ack},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      n_tests++;
      if (((k % 2 == 0) ? arb2il1_rdata : arb2dl1_rdata) !== 32'h1000 + k) begin
        n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", k,
          (k % 2 == 0) ? arb2il1_rdata : arb2dl1_rdata, 32'h1000 + k);
      end
      if (k == 3) begin
        il12arb_val = 1'b0; dl12arb_val = 1'b0;
      end
      tick();
      n_tests++;
      if ({arb2mem_val, arb2il1_ack, arb2dl1_ack} !== 3'b000) begin
        n_fail++; $display("FAIL b2b_idle%0d: got %b want 000", k, {arb2mem_val, arb2il1_ack, arb2dl1_ack});
      end
    end
    mem2arb_ack = 1'b0; mem2arb_rdata = '0;
    tick();
  endtask

  task automatic test_timeout();
    int val_cyc = 0;
    bit got_ack = 0;
    il12arb_val = 1'b1; il12arb_addr = 32'h500;
    for (int c = 0; c < 12 && !got_ack; c++) begin
      tick();
      if (arb2mem_val) val_cyc++;
      if (arb2il1_ack) begin
        got_ack = 1;
        n_tests++;
        if (arb_err !== 1'b1 || arb2il1_rdata !== 32'h0) begin
          n_fail++; $display("FAIL to_resp: got err=%b rdata=%h want err=1 rdata=00000000",
            arb_err, arb2il1_rdata);
        end
        il12arb_val = 1'b0;
      end
    end
    n_tests++;
    if (!got_ack || val_cyc != 4) begin
      n_fail++; $display("FAIL to_val_cycles: got ack=%0d val_cycles=%0d want ack=1 val_cycles=4",
        got_ack, val_cyc);
    end
    il12arb_val = 1'b0;
    tick();
    n_tests++;
    if (arb_err !== 1'b0 || arb2mem_val !== 1'b0) begin
      n_fail++; $display("FAIL to_after: got err=%b val=%b want 0 0", arb_err, arb2mem_val);
    end
  endtask

  task automatic test_ack_at_timeout();
    dl12arb_val = 1'b1; dl12arb_addr = 32'h600; dl12arb_cop = COP_RD;
    tick();
    tick();
    tick();
    tick();
    n_tests++;
    if (arb2mem_val !== 1'b1 || arb2mem_we !== 1'b0) begin
      n_fail++; $display("FAIL tie_req4: got val=%b we=%b want 1 0", arb2mem_val, arb2mem_we);
    end
    mem2arb_ack = 1'b1; mem2arb_rdata = 32'h5A5A_0606;
    tick();
    mem2arb_ack = 1'b0; mem2arb_rdata = '0;
    n_tests++;
    if ({arb2dl1_ack, arb_err} !== 2'b10 || arb2dl1_rdata !== 32'h5A5A_0606) begin
      n_fail++; $display("FAIL tie_resp: got ack=%b err=%b rdata=%h want 1 0 5a5a0606",
        arb2dl1_ack, arb_err, arb2dl1_rdata);
    end
    dl12arb_val = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    bit saw_ack = 0;
    il12arb_val = 1'b1; il12arb_addr = 32'h700;
    tick();
    dl12arb_val = 1'b1; dl12arb_addr = 32'h800; dl12arb_cop = COP_RD;
    n_tests++;
    if (arb2mem_val !== 1'b1 || arb2mem_addr !== 32'h700) begin
      n_fail++; $display("FAIL rst_pre: got val=%b addr=%h want 1 00000700", arb2mem_val, arb2mem_addr);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    n_tests++;
    if (arb2mem_val !== 1'b0 || arb2mem_addr !== 32'h0 || arb2il1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: got val=%b addr=%h rdata=%h want 0 0 0",
        arb2mem_val, arb2mem_addr, arb2il1_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (arb2il1_ack || arb2dl1_ack) saw_ack = 1;
    end
    sys_rst = 1'b0;
    n_tests++;
    if (saw_ack) begin
      n_fail++; $display("FAIL rst_no_ack: got ack during reset want none");
    end
    tick();
    n_tests++;
    if (arb2mem_val !== 1'b1 || arb2mem_addr !== 32'h700) begin
      n_fail++; $display("FAIL rst_first_il1: got val=%b addr=%h want 1 00000700",
        arb2mem_val, arb2mem_addr);
    end
    mem2arb_ack = 1'b1;
    tick();
    il12arb_val = 1'b0;
    tick();
    tick();
    n_tests++;
    if (arb2mem_val !== 1'b1 || arb2mem_addr !== 32'h800) begin
      n_fail++; $display("FAIL rst_then_dl1: got val=%b addr=%h want 1 00000800",
        arb2mem_val, arb2mem_addr);
    end
    tick();
    mem2arb_ack = 1'b0;
    n_tests++;
    if ({arb2il1_ack, arb2dl1_ack} !== 2'b01) begin
      n_fail++; $display("FAIL rst_dl1_ack: got %b want 01", {arb2il1_ack, arb2dl1_ack});
    end
    dl12arb_val = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_il1_read();
    test_dl1_write();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
